// File: rtl/serial_adder.sv
// Bit-serial add/subtract unit: one fa cell, registered carry, LSB-first sum
// shift register. WIDTH operand bits take WIDTH clocks after the accept edge.

module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;

  fa u_fa (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          shreg_d = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        carry_d = fa_cout;
        shreg_d = WIDTH'({fa_sum, shreg_q} >> 1);
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        if (last_bit) begin
          // Overflow compares the carry into the MSB with the carry out of it.
          sum_d   = shreg_d;
          cout_d  = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      shreg_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 and WIDTH=2 instances against
// an integer-arithmetic reference model.

module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start8, sub8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start2, sub2;
  logic [1:0] a2, b2;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] sum2;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start8),
    .sub      (sub8),
    .a        (a8),
    .b        (b8),
    .busy     (busy8),
    .done     (done8),
    .sum      (sum8),
    .cout     (cout8),
    .overflow (ovf8)
  );

  serial_adder #(.WIDTH(2)) u_dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start2),
    .sub      (sub2),
    .a        (a2),
    .b        (b2),
    .busy     (busy2),
    .done     (done2),
    .sum      (sum2),
    .cout     (cout2),
    .overflow (ovf2)
  );

  // Reference: plain signed/unsigned arithmetic on integers.
  function automatic void ref_op(input int w, input int a, input int b, input bit s,
                                 output int sm, output bit co, output bit ov);
    int lim, sa, sb, res_u, res_s;
    lim   = 1 << w;
    sa    = (a >= lim / 2) ? a - lim : a;
    sb    = (b >= lim / 2) ? b - lim : b;
    res_u = s ? a - b : a + b;
    res_s = s ? sa - sb : sa + sb;
    sm    = ((res_u % lim) + lim) % lim;
    co    = s ? (a >= b) : (res_u >= lim);
    ov    = (res_s < -(lim / 2)) || (res_s > lim / 2 - 1);
  endfunction

  // Drives one WIDTH=8 operation from idle and returns what it observed.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                         output int lat, output int busyc, output logic held);
    logic [7:0] prev;
    prev = sum8;
    held = 1'b1;
    @(negedge clk);
    a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
    lat = 0; busyc = 0;
    while (done8 !== 1'b1 && lat < 30) begin
      if (busy8 === 1'b1) busyc++;
      if (sum8 !== prev) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (done8 !== 1'b1) lat = -1;
  endtask

  task automatic run_op2(input logic [1:0] a, input logic [1:0] b, input logic s,
                         output int lat);
    @(negedge clk);
    a2 = a; b2 = b; sub2 = s; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    a2 = 2'($urandom); b2 = 2'($urandom);
    lat = 0;
    while (done2 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (done2 !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start2 = 1'b0; sub2 = 1'b0; a2 = '0; b2 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
      errors++;
      $display("FAIL reset8: busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
               busy8, done8, sum8, cout8, ovf8);
    end
    checks++;
    if ({busy2, done2, sum2, cout2, ovf2} !== 6'h00) begin
      errors++;
      $display("FAIL reset2: busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
               busy2, done2, sum2, cout2, ovf2);
    end
  endtask

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] sm;
    logic       co;
    logic       ov;
  } vec_t;

  task automatic test_directed();
    vec_t tbl [6];
    int lat, busyc;
    logic held;
    tbl[0] = {8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0};
    tbl[1] = {8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = {8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[3] = {8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    tbl[4] = {8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[5] = {8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      run_op8(tbl[i].a, tbl[i].b, tbl[i].s, lat, busyc, held);
      checks++;
      if (lat !== 8) begin
        errors++;
        $display("FAIL directed%0d latency: got %0d, expected 8", i, lat);
      end
      checks++;
      if (busyc !== 8) begin
        errors++;
        $display("FAIL directed%0d busy cycles: got %0d, expected 8", i, busyc);
      end
      checks++;
      if (held !== 1'b1) begin
        errors++;
        $display("FAIL directed%0d sum held during run: got %b, expected 1", i, held);
      end
      checks++;
      if ({sum8, cout8, ovf8} !== {tbl[i].sm, tbl[i].co, tbl[i].ov}) begin
        errors++;
        $display("FAIL directed%0d result: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                 i, sum8, cout8, ovf8, tbl[i].sm, tbl[i].co, tbl[i].ov);
      end
      @(negedge clk);
      checks++;
      if ({done8, busy8} !== 2'b00) begin
        errors++;
        $display("FAIL directed%0d done pulse width: got done=%b busy=%b, expected 0 0",
                 i, done8, busy8);
      end
    end
  endtask

  task automatic test_random();
    int lat, busyc, sm;
    logic held;
    bit co, ov;
    logic [7:0] ra, rb;
    logic rs;
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      ref_op(8, int'(ra), int'(rb), rs, sm, co, ov);
      run_op8(ra, rb, rs, lat, busyc, held);
      checks++;
      if (lat !== 8 || {sum8, cout8, ovf8} !== {8'(sm), co, ov}) begin
        errors++;
        $display("FAIL random %h%s%h: got lat=%0d sum=%h cout=%b ovf=%b, expected lat=8 sum=%h cout=%b ovf=%b",
                 ra, rs ? "-" : "+", rb, lat, sum8, cout8, ovf8, 8'(sm), co, ov);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_start();
    int k;
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    k = 0;
    while (done8 !== 1'b1 && k < 30) begin
      start8 = (k < 6) && (k % 2 == 0);
      a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
      @(negedge clk);
      k++;
    end
    checks++;
    if (done8 !== 1'b1 || sum8 !== 8'h46 || cout8 !== 1'b0 || ovf8 !== 1'b0) begin
      errors++;
      $display("FAIL ignore_run: got done=%b sum=%h cout=%b ovf=%b, expected done=1 sum=46 cout=0 ovf=0",
               done8, sum8, cout8, ovf8);
    end
    // Start during DONE must also be dropped.
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    @(negedge clk);
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b0) begin
      errors++;
      $display("FAIL ignore_done: got busy=%b, expected 0", busy8);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({sum8, done8, busy8} !== {8'h46, 2'b00}) begin
        errors++;
        $display("FAIL hold_idle%0d: got sum=%h done=%b busy=%b, expected sum=46 done=0 busy=0",
                 i, sum8, done8, busy8);
      end
    end
  endtask

  task automatic test_reset_abort();
    int dones, lat, busyc;
    logic held;
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h11; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
      errors++;
      $display("FAIL abort_async: got busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
               busy8, done8, sum8, cout8, ovf8);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 === 1'b1 || busy8 === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done/busy cycles, expected 0", dones);
    end
    run_op8(8'h10, 8'h20, 1'b0, lat, busyc, held);
    checks++;
    if (lat !== 8 || {sum8, cout8, ovf8} !== {8'h30, 2'b00}) begin
      errors++;
      $display("FAIL abort_restart: got lat=%0d sum=%h cout=%b ovf=%b, expected lat=8 sum=30 cout=0 ovf=0",
               lat, sum8, cout8, ovf8);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic       vs [4];
    int n, sm;
    bit co, ov;
    for (int i = 0; i < 4; i++) begin
      va[i] = 8'($urandom); vb[i] = 8'($urandom); vs[i] = 1'($urandom);
    end
    @(negedge clk);
    a8 = va[0]; b8 = vb[0]; sub8 = vs[0]; start8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (done8 !== 1'b1 && n < 40);
      ref_op(8, int'(va[i]), int'(vb[i]), vs[i], sm, co, ov);
      checks++;
      if (done8 !== 1'b1 || {sum8, cout8, ovf8} !== {8'(sm), co, ov}) begin
        errors++;
        $display("FAIL b2b%0d result: got done=%b sum=%h cout=%b ovf=%b, expected done=1 sum=%h cout=%b ovf=%b",
                 i, done8, sum8, cout8, ovf8, 8'(sm), co, ov);
      end
      if (i > 0) begin
        checks++;
        if (n !== 10) begin
          errors++;
          $display("FAIL b2b%0d interval: got %0d cycles, expected 10", i, n);
        end
      end
      if (i < 3) begin
        a8 = va[i+1]; b8 = vb[i+1]; sub8 = vs[i+1];
      end else begin
        start8 = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_exhaustive2();
    int lat, sm;
    bit co, ov;
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        for (int is = 0; is < 2; is++) begin
          ref_op(2, ia, ib, is[0], sm, co, ov);
          run_op2(2'(ia), 2'(ib), is[0], lat);
          checks++;
          if (lat !== 2 || {sum2, cout2, ovf2} !== {2'(sm), co, ov}) begin
            errors++;
            $display("FAIL w2 %0d%s%0d: got lat=%0d sum=%0d cout=%b ovf=%b, expected lat=2 sum=%0d cout=%b ovf=%b",
                     ia, is ? "-" : "+", ib, lat, sum2, cout2, ovf2, sm, co, ov);
          end
          @(negedge clk);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_exhaustive2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial add/subtract unit built around a single `fa` full-adder cell. It accepts a WIDTH-bit operand pair on a start strobe and feeds one bit per clock, LSB first, into the `fa` instance. A registered carry closes the loop, and a shift register collects the `fa` sum outputs. It sits directly upstream and downstream of `fa`: it sequences the cell's inputs and consumes its sum/cout. It gives the multi-stage datapath a minimum-area adder at the cost of WIDTH-cycle latency.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  in  1  rising-edge clock; sole clock.
- rst_n  in  1  asynchronous, active-low reset; deasserted synchronously to clk.
- start  in  1  request strobe; accepted only in IDLE.
- sub  in  1  0 = a+b, 1 = a-b; sampled with start.
- a  in  WIDTH  operand A; sampled on the accepting edge.
- b  in  WIDTH  operand B; sampled on the accepting edge.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse: result valid.
- sum  out  WIDTH  result; held from done until the next completion.
- cout  out  1  carry out of MSB; for sub, 1 = no borrow.
- overflow  out  1  two's-complement overflow, i.e. carry into MSB XOR carry out of MSB.

## Operation
- States:
  - IDLE → RUN on start=1.
  - RUN → DONE when the bit counter reaches WIDTH-1 and that bit is processed.
  - DONE → IDLE unconditionally.
- Accept, at the IDLE edge with start=1:
  - opA ← a.
  - opB ← sub ? ~b : b.
  - carry ← sub.
  - cnt ← 0.
  - shift register ← 0.
- Each RUN edge:
  - `fa` inputs: a=opA[0], b=opB[0], cin=carry.
  - carry ← fa.cout.
  - Shift register ← {fa.sum, shreg[WIDTH-1:1]}.
  - opA and opB shift right by 1.
  - cnt ← cnt+1.
- Final RUN edge (cnt=WIDTH-1):
  - sum ← completed shift-register value.
  - cout ← fa.cout.
  - overflow ← carry XOR fa.cout, using the carry value before this edge.
  - done ← 1.
- DONE edge: done ← 0. sum, cout and overflow are held.
- start while in RUN or DONE is ignored; nothing is queued.
- Only `fa` performs addition; no `+` operator on the datapath.
- Results wrap modulo 2^WIDTH; cout and overflow carry the out-of-range information.
- cnt is $clog2(WIDTH) bits wide and never wraps within an operation.

## Timing
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, overflow=0. Internal registers are also 0.
- Accept edge = edge 0.
  - busy is high after edge 0 through edge WIDTH.
  - done is high for exactly one cycle, after edge WIDTH.
  - sum, cout and overflow change only at edge WIDTH.
- Earliest next accept is the edge after done, i.e. the IDLE edge. Minimum issue interval is WIDTH+2 cycles.
- a, b and sub may change freely after edge 0.
- Reset asserted mid-operation aborts immediately and asynchronously:
  - All outputs return to reset values.
  - No done pulse follows.
  - The first start after deassertion is accepted normally.
- start held high continuously re-issues with the then-current a/b every WIDTH+2 cycles.

## Test plan
- WIDTH=8, add: 0x3C+0x0F → sum=0x4B, cout=0, overflow=0. done pulses exactly 8 cycles after the accept edge, for 1 cycle. busy is high for 8 cycles.
- WIDTH=8, add, boundary cases:
  - 0xFF+0x01 → sum=0x00, cout=1, overflow=0.
  - 0x7F+0x01 → sum=0x80, cout=0, overflow=1.
- WIDTH=8, sub:
  - 0x05-0x07 → sum=0xFE, cout=0, overflow=0.
  - 0x80-0x01 → sum=0x7F, cout=1, overflow=1.
  - 0x00-0x00 → sum=0x00, cout=1.
- Pulse start again and change a/b during busy → ignored. The original result is unchanged. The result is then held for 3 further idle cycles with no start.
- Assert rst_n=0 at cycle 4 of an operation → outputs 0 asynchronously, no done. Then 0x10+0x20 → 0x30.
- WIDTH=2 exhaustive: all 16 operand pairs × sub, checked against a reference model for sum/cout/overflow.
